// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_e : controller states (IDLE, BUSY, DONE)
//   DIV_DW      : default divisor/quotient/remainder width
//   div_cnt_w() : step-counter width for a given data width
//   DIV_CW      : step-counter width for the default data width
package div_pkg;

    localparam int unsigned DIV_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Counter must hold 0..dw.
    function automatic int unsigned div_cnt_w(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

    localparam int unsigned DIV_CW = div_cnt_w(DIV_DW);

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step.
// Ports:
//   rem      [DW-1:0] in  current partial remainder (always < divisor)
//   in_bit            in  next dividend bit shifted into the remainder
//   divisor  [DW-1:0] in  divisor
//   rem_next [DW-1:0] out updated partial remainder
//   q_bit             out quotient bit produced by this step
module div_restore_step
    import div_pkg::*;
#(
    parameter int unsigned DW = DIV_DW
) (
    input  logic [DW-1:0] rem,
    input  logic          in_bit,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_next,
    output logic          q_bit
);

    // DW+1 bits so the remainder MSB is not lost by the shift.
    logic [DW:0] trial;
    logic [DW:0] diff;

    always_comb begin
        trial = {rem, in_bit};
        diff  = trial - {1'b0, divisor};
        q_bit = (trial >= {1'b0, divisor});
        // rem < divisor on entry, so a successful subtract always fits in DW bits.
        rem_next = q_bit ? diff[DW-1:0] : trial[DW-1:0];
    end

endmodule

// File: rtl/unsigned_div_16by8_seq.sv
// Sequential unsigned restoring divider: 2*DW-bit dividend / DW-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
// Optional build macro: DIV_BYPASS_EN adds 1-cycle shortcuts for divisor==1
// and dividend==0.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; dividend [2*DW-1:0], divisor [DW-1:0]
//   out_valid / out_ready result handshake
//   quotient, remainder   DW-bit results, meaningful while out_valid=1
//   div_by_zero           divisor was zero (quotient all ones, remainder = dividend low half)
//   overflow              quotient would not fit in DW bits (quotient all ones, remainder 0)
module unsigned_div_16by8_seq
    import div_pkg::*;
#(
    parameter int unsigned DW = DIV_DW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero,
    output logic            overflow
);

    localparam int unsigned CW = div_cnt_w(DW);

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rem_q, rem_d;
    // Dividend low bits shift out of the top while quotient bits enter at the
    // bottom; after DW steps it holds the quotient.
    logic [DW-1:0] shreg_q, shreg_d;
    logic [DW-1:0] dv_q, dv_d;
    logic          dbz_q, dbz_d;
    logic          ovf_q, ovf_d;

    logic [DW-1:0] step_rem;
    logic          step_q_bit;

    div_restore_step #(
        .DW (DW)
    ) u_step (
        .rem      (rem_q),
        .in_bit   (shreg_q[DW-1]),
        .divisor  (dv_q),
        .rem_next (step_rem),
        .q_bit    (step_q_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        shreg_d = shreg_q;
        dv_d    = dv_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dv_d  = divisor;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        shreg_d = '1;
                        rem_d   = dividend[DW-1:0];
                    end else if (dividend[2*DW-1:DW] >= divisor) begin
                        // Quotient would need more than DW bits.
                        state_d = DONE;
                        ovf_d   = 1'b1;
                        shreg_d = '1;
                        rem_d   = '0;
                    end
`ifdef DIV_BYPASS_EN
                    else if (divisor == DW'(1)) begin
                        state_d = DONE;
                        shreg_d = dividend[DW-1:0];
                        rem_d   = '0;
                    end else if (dividend == '0) begin
                        state_d = DONE;
                        shreg_d = '0;
                        rem_d   = '0;
                    end
`endif
                    else begin
                        state_d = BUSY;
                        rem_d   = dividend[2*DW-1:DW];
                        shreg_d = dividend[DW-1:0];
                    end
                end
            end

            BUSY: begin
                rem_d   = step_rem;
                shreg_d = {shreg_q[DW-2:0], step_q_bit};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            shreg_q <= '0;
            dv_q    <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            shreg_q <= shreg_d;
            dv_q    <= dv_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        quotient    = shreg_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
        overflow    = ovf_q;
    end

endmodule

// File: tb/tb_unsigned_div_16by8_seq.sv
// Scoreboard bench for unsigned_div_16by8_seq: the driver pushes the expected
// result of each accepted operand pair; a monitor pops and compares whenever
// a new result appears on out_valid.
module tb_unsigned_div_16by8_seq;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   dividend = '0;
    logic [7:0]    divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    quotient;
    logic [7:0]    remainder;
    logic          div_by_zero;
    logic          overflow;

    unsigned_div_16by8_seq #(
        .DW (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division plus the exception rules.
    // lat counts rising edges from the accepting edge (inclusive) until
    // out_valid is visible: 1 for direct-to-DONE, accept edge + DW steps otherwise.
    function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv);
        exp_t e;
        int unsigned quo;
        e.dd = dd;
        e.dv = dv;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.acc = 0;
        if (dv == 0) begin
            e.dbz = 1'b1;
            e.q   = 8'hFF;
            e.r   = dd[7:0];
            e.lat = 1;
        end else begin
            quo = int'(dd) / int'(dv);
            if (quo > 255) begin
                e.ovf = 1'b1;
                e.q   = 8'hFF;
                e.r   = 8'h00;
                e.lat = 1;
            end else begin
                e.q   = 8'(quo);
                e.r   = 8'(int'(dd) % int'(dv));
                e.lat = DW + 1;
`ifdef DIV_BYPASS_EN
                if (dv == 1 || dd == 0) e.lat = 1;
`endif
            end
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor
    initial begin : mon
        exp_t        e;
        logic        prev_v;
        logic [17:0] held;
        logic [31:0] recon;
        prev_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else if (out_valid && !prev_v) begin
                prev_v = 1'b1;
                held = {quotient, remainder, div_by_zero, overflow};
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got q=%0h r=%0h expected no result",
                             quotient, remainder);
                end else begin
                    e = sb.pop_front();
                    check("quotient", 32'(quotient), 32'(e.q));
                    check("remainder", 32'(remainder), 32'(e.r));
                    check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    check("overflow", 32'(overflow), 32'(e.ovf));
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                    if (!e.dbz && !e.ovf) begin
                        recon = 32'(quotient) * 32'(e.dv) + 32'(remainder);
                        check("invariant", 32'((recon == 32'(e.dd)) && (remainder < e.dv)), 32'd1);
                    end
                end
            end else if (out_valid) begin
                check("hold_stable", 32'({quotient, remainder, div_by_zero, overflow}), 32'(held));
                check("in_ready_in_done", 32'(in_ready), 32'd0);
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    // Present one operand pair when in_ready; returns on the negedge after the accept edge.
    task automatic issue(input logic [15:0] dd, input logic [7:0] dv);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        e = model(dd, dv);
        e.acc = cyc;
        sb.push_back(e);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        // Operands are only sampled on the accept edge.
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(sb.size() == 0 && in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !in_ready) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin : drv
        int          n;
        logic [7:0]  dv;
        logic [15:0] dd;
        int unsigned sel;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({quotient, remainder, div_by_zero, overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        issue(16'h03E8, 8'd7);    drain();
        issue(16'hFE01, 8'hFF);   drain();
        issue(16'hFF00, 8'hFF);   drain();
        issue(16'h1234, 8'h00);   drain();
        issue(16'h00AB, 8'h01);   drain();
        issue(16'h0000, 8'h35);   drain();

        // Backpressure with stray in_valid pulses in BUSY and DONE
        out_ready = 1'b0;
        issue(16'h03E8, 8'd7);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_exit_out_valid", 32'(out_valid), 32'd0);
        check("bp_exit_in_ready", 32'(in_ready), 32'd1);
        drain();

        // Reset during BUSY step 4
        issue(16'h03E8, 8'd7);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", 32'({quotient, remainder, div_by_zero, overflow}), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h0064, 8'd10);   drain();

        // Random regression with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            dv  = 8'($urandom);
            dd  = 16'($urandom);
            if (sel == 0) dv = 8'h00;
            else if (sel == 1) dv = 8'h01;
            else if (sel == 2) dd = 16'h0000;
            else if (sel >= 4 && dv != 0) dd = 16'($urandom_range(0, int'(dv) * 256 - 1));
            issue(dd, dv);
        end
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
